// File: rtl/rf_ctrl_pkg.sv
// Shared constants and bus-slicing helpers for the register-file writeback control block.
package rf_ctrl_pkg;

   localparam int XLEN     = 64;
   localparam int REG_AW   = 5;
   localparam int NREG     = 32;
   localparam int ZERO_REG = 0;
   localparam int MAX_REQ  = 4;

   // Callers zero-extend their packed address bus to MAX_REQ slots before slicing.
   function automatic logic [REG_AW-1:0] addr_slice(input logic [REG_AW*MAX_REQ-1:0] bus,
                                                    input int                         i);
      return bus[i*REG_AW +: REG_AW];
   endfunction

   function automatic logic [XLEN-1:0] data_slice(input logic [XLEN*MAX_REQ-1:0] bus,
                                                  input int                       i);
      return bus[i*XLEN +: XLEN];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, none when en is low.
module rr_arbiter #(
   parameter  int N  = 3,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  grant
);

   always_comb begin
      logic found;
      grant = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (en && !found && req[(int'(ptr) + k) % N]) begin
            grant[(int'(ptr) + k) % N] = 1'b1;
            found                      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback sources and tracks
// pending destination registers so issue can stall on RAW/WAW hazards.
module rf_wb_arbiter
   import rf_ctrl_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int XLEN = 64,
   parameter int NREG = 32
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   HOLD,
   input  logic [NREQ-1:0]        REQ_VALID,
   output logic [NREQ-1:0]        REQ_READY,
   input  logic [REG_AW*NREQ-1:0] REQ_ADDR,
   input  logic [XLEN*NREQ-1:0]   REQ_DATA,
   output logic                   RF_WE,
   output logic [REG_AW-1:0]      RF_WR_ADDR,
   output logic [XLEN-1:0]        RF_WR_DATA,
   input  logic                   ISSUE_VALID,
   input  logic [REG_AW-1:0]      ISSUE_RD,
   input  logic [REG_AW-1:0]      ISSUE_RS1,
   input  logic [REG_AW-1:0]      ISSUE_RS2,
   output logic                   STALL,
   output logic [NREG-1:0]        BUSY_MASK
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]             ptr_q, ptr_d;
   logic                      we_q, we_d;
   logic [REG_AW-1:0]         addr_q, addr_d;
   logic [XLEN-1:0]           data_q, data_d;
   logic [NREG-1:0]           busy_q, busy_d;

   logic [NREQ-1:0]           grant;
   logic [REG_AW*MAX_REQ-1:0] addr_bus;
   logic                      accept;
   logic [REG_AW-1:0]         sel_addr;
   logic [XLEN-1:0]           sel_data;
   logic                      issue_fire;

   // Grants are suppressed while in reset so nothing is consumed in the reset cycle.
   rr_arbiter #(.N(NREQ)) u_arb (
      .req   (REQ_VALID),
      .ptr   (ptr_q),
      .en    (RESET && !HOLD),
      .grant (grant)
   );

   assign REQ_READY = grant;

   always_comb begin
      addr_bus                    = '0;
      addr_bus[REG_AW*NREQ-1:0]   = REQ_ADDR;
      accept                      = 1'b0;
      sel_addr                    = '0;
      sel_data                    = '0;
      ptr_d                       = ptr_q;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            accept   = 1'b1;
            sel_addr = addr_slice(addr_bus, i);
            sel_data = REQ_DATA[i*XLEN +: XLEN];
            ptr_d    = PW'((i + 1) % NREQ);
         end
      end
   end

   always_comb begin
      we_d   = accept && (sel_addr != REG_AW'(ZERO_REG));
      addr_d = accept ? sel_addr : addr_q;
      data_d = accept ? sel_data : data_q;
   end

   // No bypass: a write retiring this cycle still stalls until busy_q updates.
   assign STALL      = ISSUE_VALID && (busy_q[ISSUE_RS1] || busy_q[ISSUE_RS2] || busy_q[ISSUE_RD]);
   assign issue_fire = ISSUE_VALID && !STALL && (ISSUE_RD != REG_AW'(ZERO_REG));

   // Set is applied after clear so a newly issued writer to the same register stays pending.
   always_comb begin
      busy_d = busy_q;
      if (accept)     busy_d[sel_addr] = 1'b0;
      if (issue_fire) busy_d[ISSUE_RD] = 1'b1;
      busy_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         ptr_q  <= '0;
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         busy_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
         busy_q <= busy_d;
      end
   end

   assign RF_WE      = we_q;
   assign RF_WR_ADDR = addr_q;
   assign RF_WR_DATA = data_q;
   assign BUSY_MASK  = busy_q;

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between NREQ writeback sources (ALU, load unit, multi-cycle mul/div) using round-robin arbitration with a valid/ready handshake.
- Keeps a scoreboard of destination registers with writes still outstanding, and raises STALL to the issue stage on RAW or WAW hazards.
- Sits between the writeback sources and the 32x64 register file.
- Drives the file's WE / WR_ADDR / WR_DATA from registered outputs. The file captures on the falling edge.

Parameters:
- NREQ, 3, number of writeback requesters; legal range 2..4.
- XLEN, 64, data width.
- NREG, 32, architectural register count; register 0 is hardwired zero.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- HOLD  in  1  pipeline freeze; suppresses grants while high.
- REQ_VALID  in  NREQ  per-source write request.
- REQ_READY  out  NREQ  per-source grant; combinational, one-hot or zero.
- REQ_ADDR  in  5*NREQ  packed destination register index; source i at bits [5i+4:5i].
- REQ_DATA  in  XLEN*NREQ  packed write data.
- RF_WE  out  1  register-file write enable; registered.
- RF_WR_ADDR  out  5  register-file write address; registered.
- RF_WR_DATA  out  XLEN  register-file write data; registered.
- ISSUE_VALID  in  1  issue stage presents an instruction.
- ISSUE_RD  in  5  destination of the issuing instruction.
- ISSUE_RS1  in  5  first source of the issuing instruction.
- ISSUE_RS2  in  5  second source of the issuing instruction.
- STALL  out  1  issue must hold; combinational.
- BUSY_MASK  out  NREG  scoreboard state; bit 0 is always 0.

Behaviour:
- Reset (RESET=0, asynchronous, any time):
  - RF_WE=0, RF_WR_ADDR=0, RF_WR_DATA=0.
  - BUSY_MASK=0, round-robin pointer PTR=0.
  - A transfer in flight is dropped. No RF write occurs in the reset cycle.
- Arbitration (combinational):
  - If HOLD=1: all REQ_READY=0.
  - Otherwise grant the first i with REQ_VALID[i]=1, searching PTR, PTR+1, ... mod NREQ.
  - REQ_READY never depends on RF state, because the output register drains every cycle.
- Transfer: a source is accepted on a rising edge where REQ_VALID[i] && REQ_READY[i]. At that edge:
  - RF_WR_ADDR <= REQ_ADDR[i]; RF_WR_DATA <= REQ_DATA[i].
  - RF_WE <= (REQ_ADDR[i] != 0).
  - PTR <= (i+1) mod NREQ.
- No transfer at an edge: RF_WE <= 0. Address and data hold their previous values. PTR is unchanged.
- Latency: accepted at edge N. RF_* are valid throughout cycle N+1, and the file captures at the falling edge inside N+1.
- Sources keep valid/data stable until accepted. VALID must not drop before READY; this is a bench assertion.
- Writes to x0 are granted and consumed, but produce RF_WE=0.
- Scoreboard:
  - busy[r] is set when ISSUE_VALID && !STALL && ISSUE_RD==r && r!=0.
  - busy[r] is cleared when a transfer with addr r is accepted.
  - Set and clear of the same r at one edge: set wins (a newer write is pending).
- STALL = ISSUE_VALID && (busy[ISSUE_RS1] || busy[ISSUE_RS2] || busy[ISSUE_RD]).
  - Index 0 never counts as busy.
  - STALL uses the registered busy state only; there is no same-cycle bypass of a clearing write.
- HOLD does not affect the scoreboard or STALL.

Decomposition:
- Package rf_ctrl_pkg holds:
  - XLEN, REG_AW=5, NREG, and ZERO_REG=0.
  - A helper function that extracts slice i of the packed request buses.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], ptr, en.
  - Output: grant[N], one-hot or zero.
  - Purely combinational.
  - rf_wb_arbiter holds PTR and instantiates rr_arbiter.

Test Plan:
- Reset: hold RESET=0 with all REQ_VALID=1 -> REQ_READY=0, RF_WE=0, BUSY_MASK=0. Release reset -> source 0 is granted first.
- Round-robin: all three sources valid continuously with addrs 5/6/7 -> grants cycle 0,1,2,0,...; RF_WR_ADDR sequence 5,6,7,5 one cycle later, RF_WE=1 each cycle.
- HOLD: HOLD=1 for 3 cycles with sources valid -> REQ_READY=0 and RF_WE=0 for those cycles. Drop HOLD -> the grant resumes at the saved PTR.
- x0 write: source 1 writes addr 0, data 0xDEAD -> granted, RF_WE=0 next cycle, PTR advances to 2.
- RAW hazard: issue rd=9, then issue rs1=9 -> STALL=1 until source 2 writes addr 9. STALL=0 in the cycle after that accept. BUSY_MASK[9] goes 1 then 0.
- Set/clear collision and mid-op reset:
  - Issue rd=4 at the same edge that a write to 4 is accepted -> BUSY_MASK[4]=1.
  - Assert RESET mid-burst -> RF_WE drops to 0 immediately and BUSY_MASK clears asynchronously.
